// File: rtl/phy_rx_pkg.sv
// Shared definitions for the receive-side serial PHY: comma character,
// default lock length and the lock FSM state encoding.
package phy_rx_pkg;

  localparam logic [7:0] COMMA_BC           = 8'hBC;
  localparam int         LOCK_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNING = 2'd1,
    ACTIVE   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_bit_deserializer.sv
// Bit-level front end: serial shift history, candidate byte and the
// byte-boundary counter that the lock FSM can re-phase on a comma hit.
module rx_bit_deserializer (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       realign,
  output logic [7:0] nxt,
  output logic       boundary
);

  // Only the newest 7 bits are ever needed: the 8th comes straight off the lane.
  logic [6:0] sr_reg;
  logic [2:0] bit_cnt_reg;

  assign nxt      = {sr_reg, serial_in};
  assign boundary = (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr_reg      <= '0;
      bit_cnt_reg <= '0;
    end else begin
      sr_reg      <= nxt[6:0];
      bit_cnt_reg <= realign ? 3'd0 : bit_cnt_reg + 3'd1;
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Comma-aligned serial-to-parallel receiver: hunts for COMMA, locks after
// LOCK_COUNT aligned commas, then emits one byte per 8 clocks.
module serial_to_parallel_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_BC,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       idle_out,
  output logic       byte_stb,
  output logic       active
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  rx_state_t  state_reg;
  logic [3:0] bc_cnt_reg;
  logic [7:0] nxt;
  logic       boundary;
  logic       is_comma;
  logic       realign;

  assign is_comma = (nxt == COMMA);
  // Any comma seen while hunting defines the byte phase from the next edge on.
  assign realign  = (state_reg == UNLOCKED) && is_comma;

  rx_bit_deserializer u_deser (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .serial_in (serial_in),
    .realign   (realign),
    .nxt       (nxt),
    .boundary  (boundary)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_reg  <= UNLOCKED;
      bc_cnt_reg <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      idle_out   <= 1'b0;
      byte_stb   <= 1'b0;
      active     <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      case (state_reg)
        UNLOCKED: begin
          if (is_comma) begin
            bc_cnt_reg <= 4'd1;
            state_reg  <= ALIGNING;
          end
        end
        ALIGNING: begin
          if (boundary) begin
            if (is_comma) begin
              bc_cnt_reg <= bc_cnt_reg + 4'd1;
              if (bc_cnt_reg + 4'd1 == LOCK_CNT) begin
                state_reg <= ACTIVE;
                active    <= 1'b1;
              end
            end else begin
              bc_cnt_reg <= '0;
              state_reg  <= UNLOCKED;
            end
          end
        end
        ACTIVE: begin
          // Lock is sticky; only reset leaves this state.
          if (boundary) begin
            data_out  <= nxt;
            valid_out <= !is_comma;
            idle_out  <= is_comma;
            byte_stb  <= 1'b1;
          end
        end
        default: begin
          state_reg  <= UNLOCKED;
          bc_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Scoreboard bench for serial_to_parallel_rx: stimulus queues expected bytes,
// a negedge monitor checks strobes, lock timing and strobe spacing.
module tb_serial_to_parallel_rx;

  localparam logic [7:0] BC = 8'hBC;

  typedef struct {
    logic [7:0] data;
    logic       idle;
  } exp_t;

  logic       clk_32f;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       idle_out;
  logic       byte_stb;
  logic       active;

  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;
  int   last_byte_edge = 0;
  int   exp_active_edge = -1;
  int   lock_edge = -1;
  int   last_stb_edge = -1;
  logic active_q = 1'b0;
  exp_t sb_q[$];

  logic [7:0] tx_tab [16] = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h12, 8'hED,
                              8'h5E, 8'h2F, 8'h97, 8'h4B, 8'hA6, 8'hD3, 8'h69, 8'h01};

  serial_to_parallel_rx dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .idle_out  (idle_out),
    .byte_stb  (byte_stb),
    .active    (active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  always @(posedge clk_32f) edge_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: lock timing, strobe spacing and scoreboard comparison.
  always @(negedge clk_32f) begin
    exp_t e;
    int   exp_e;
    if (!reset) begin
      active_q      = 1'b0;
      lock_edge     = -1;
      last_stb_edge = -1;
    end else begin
      if (active && !active_q) begin
        checks++;
        if (exp_active_edge < 0 || edge_n != exp_active_edge) begin
          failures++;
          $display("FAIL active_rise edge=%0d expected=%0d", edge_n, exp_active_edge);
        end
        lock_edge = edge_n;
      end
      active_q = active;
      if (byte_stb) begin
        exp_e = (last_stb_edge < 0) ? lock_edge + 8 : last_stb_edge + 8;
        checks++;
        if (lock_edge < 0 || edge_n != exp_e) begin
          failures++;
          $display("FAIL stb_timing edge=%0d expected=%0d", edge_n, exp_e);
        end
        last_stb_edge = edge_n;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_stb data=%02h valid=%0b idle=%0b expected=none",
                   data_out, valid_out, idle_out);
        end else begin
          e = sb_q.pop_front();
          if (data_out !== e.data || valid_out !== !e.idle || idle_out !== e.idle) begin
            failures++;
            $display("FAIL byte data=%02h valid=%0b idle=%0b expected data=%02h valid=%0b idle=%0b",
                     data_out, valid_out, idle_out, e.data, !e.idle, e.idle);
          end else begin
            $display("rx byte %02h valid=%0b idle=%0b at edge %0d",
                     data_out, valid_out, idle_out, edge_n);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    serial_in = b;
  endtask

  // Transmitter model: MSB first, one bit per clock.
  task automatic send_byte(input logic [7:0] b, input bit push);
    exp_t e;
    if (push) begin
      e.data = b;
      e.idle = (b == BC);
      sb_q.push_back(e);
    end
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    last_byte_edge = edge_n + 1;
  endtask

  task automatic lock_run();
    send_byte(BC, 1'b0);
    exp_active_edge = last_byte_edge + 24;
    repeat (3) send_byte(BC, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b0;
    serial_in = 1'b0;
    exp_active_edge = -1;
    sb_q.delete();
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      @(negedge clk_32f);
      #2;
    end
    chk({name, "_drain_left"}, sb_q.size(), 0);
    chk({name, "_active"}, {31'd0, active}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    serial_in = 1'b0;

    // Reset held with random lane activity.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_32f);
      serial_in = 1'($urandom_range(0, 1));
      #1;
      chk("reset_hold", {20'd0, data_out, valid_out, idle_out, byte_stb, active}, 0);
    end
    @(negedge clk_32f);
    reset = 1'b1;
    repeat (64) send_bit(1'b0);
    #1;
    chk("zeros_no_active", {31'd0, active}, 0);
    $display("test reset done");

    // Basic lock and first payload.
    do_reset();
    lock_run();
    send_byte(8'h5A, 1'b1);
    send_byte(BC, 1'b1);
    send_byte(8'hFF, 1'b1);
    drain("lock");
    $display("test lock done");

    // Three junk bits before the commas.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock_run();
    send_byte(8'h3C, 1'b1);
    drain("misalign");
    $display("test misaligned done");

    // Lock run broken by a non-comma, then a clean run.
    do_reset();
    send_byte(BC, 1'b0);
    send_byte(BC, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("broken_no_active", {31'd0, active}, 0);
    lock_run();
    send_byte(8'hA5, 1'b1);
    drain("broken");
    $display("test broken run done");

    // Reset mid-byte after payload, then relock.
    do_reset();
    lock_run();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    drain("mid_pre");
    @(negedge clk_32f);
    reset = 1'b0;
    exp_active_edge = -1;
    sb_q.delete();
    #1;
    chk("async_clear", {20'd0, data_out, valid_out, idle_out, byte_stb, active}, 0);
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    lock_run();
    send_byte(8'h77, 1'b1);
    drain("relock");
    $display("test mid-stream reset done");

    // Loopback: idle commas then 16 bytes from the transmitter model.
    do_reset();
    lock_run();
    send_byte(BC, 1'b1);
    send_byte(BC, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(tx_tab[i], 1'b1);
    drain("loopback");
    $display("test loopback done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Receive-side deserializer matching the team's parallel-to-serial transmitter. Samples the serial lane on `clk_32f`, hunts for the BC comma character (8'hBC) to find byte alignment, and declares the link active after a run of aligned BC characters. It then delivers one byte every 8 clocks, flagging idle (BC) bytes separately from payload. It sits between the serial lane and the byte-striping/unstriping logic.

## Interface
Parameters:
- `COMMA`, 8'hBC, alignment/idle character
- `LOCK_COUNT`, 4, consecutive aligned COMMAs required to assert `active`; range 2..15

Ports:
- `clk_32f`  input  1  bit clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low; 0 clears all state immediately
- `serial_in`  input  1  serial lane, MSB first, one bit per `clk_32f`
- `data_out`  output  8  last completed byte, held between strobes
- `valid_out`  output  1  `data_out` is payload (non-COMMA), held between strobes
- `idle_out`  output  1  `data_out` is COMMA, held between strobes
- `byte_stb`  output  1  one-cycle pulse at each byte boundary while active
- `active`  output  1  link locked and delivering bytes

## Operation
- Shift register: each edge `sr <= {sr[6:0], serial_in}`; candidate byte `nxt = {sr[6:0], serial_in}`.
- Bit counter `bit_cnt` (3 bits); a boundary edge is one with `bit_cnt == 7`, then wraps to 0.
- Lock counter `bc_cnt` (4 bits).
- States:
  - UNLOCKED: `bit_cnt` is ignored. On any edge with `nxt == COMMA`: `bit_cnt <= 0`, `bc_cnt <= 1`, go ALIGNING.
  - ALIGNING: `bit_cnt` increments. At a boundary:
    - if `nxt == COMMA`, `bc_cnt++`; when the incremented value equals `LOCK_COUNT`, go ACTIVE and set `active <= 1`.
    - if `nxt != COMMA`, go UNLOCKED with `bc_cnt <= 0`. The hunt restarts on the next edge.
  - ACTIVE: at each boundary, `data_out <= nxt`, `valid_out <= (nxt != COMMA)`, `idle_out <= (nxt == COMMA)`, `byte_stb <= 1`. `byte_stb <= 0` on all other edges. ACTIVE is left only through reset.
- The lock-completing boundary itself produces no output. The first strobe comes on the next boundary.
- No output changes in UNLOCKED or ALIGNING. COMMA-looking bit patterns that straddle boundaries are ignored once aligned.
- `bc_cnt` saturates at `LOCK_COUNT`.

## Timing
- Reset values: `data_out` = 8'h00; `valid_out`, `idle_out`, `byte_stb`, `active` = 0. Also `sr` = 0, `bit_cnt` = 0, `bc_cnt` = 0, state UNLOCKED.
- Detection edge E0 is the edge that samples the last bit of the first COMMA.
- The k-th following COMMA completes at edge E0+8k.
- `active` rises on the register update at edge E0+8·(LOCK_COUNT−1). With the default, that is E0+24.
- Output latency: byte bits sampled on edges B−7..B appear on `data_out`, `valid_out`, `idle_out` after edge B. `byte_stb` is high for exactly the cycle after B.
- Strobe period is exactly 8 clocks, with no gaps, while ACTIVE.
- Reset asserted mid-byte or mid-lock clears everything asynchronously. After release, the first edge behaves as UNLOCKED with `sr` = 0.
- A non-COMMA byte at boundary E0+8k (k < LOCK_COUNT−1) drops to UNLOCKED at that edge. No partial lock is retained.

## Structure
- Shared package `phy_rx_pkg`: `COMMA_BC` = 8'hBC, default `LOCK_COUNT`, and the state enum/encoding (UNLOCKED, ALIGNING, ACTIVE).
- One sub-module, `rx_bit_deserializer`, containing the shift register, `bit_cnt`, and the `nxt`/boundary outputs. The top level holds the lock FSM and the output registers.

## Test plan
- Reset: hold `reset` = 0 while driving random `serial_in` -> all outputs 0, no `byte_stb`. Release, send nothing but 0s for 64 clocks -> `active` stays 0.
- Lock: send BC×4, then 8'h5A, 8'hBC, 8'hFF -> `active` rises 24 clocks after the first BC's last bit. Then strobes show `data_out` 5A/`valid_out`=1, BC/`idle_out`=1, FF/`valid_out`=1, every 8 clocks.
- Misaligned start: prefix 3 junk bits (101) before BC×4, 8'h3C -> lock still achieved, and the first strobe shows 3C/`valid_out`=1.
- Broken lock run: BC, BC, 8'h00, then BC×4, 8'hA5 -> no `active` during the first run. `active` rises 24 clocks after the restart, then A5 is delivered.
- Mid-stream reset: after lock and 2 payload bytes, pulse `reset` low for 3 clocks mid-byte -> all outputs go to 0 immediately. A fresh BC×4 relocks with the same 24-clock timing.
- Transmitter loopback: connect the parallel-to-serial transmitter's serial output to `serial_in` and send 16 random bytes after idle -> received payload bytes match in order, with no extra `valid_out` strobes.
